pmem_line_responder: RTL and testbench

Line-granular physical-memory responder on the memory side of the cache arbiter's `pmem_*` interface. It accepts one 256-bit line read or write at a time from the arbiter, holds it for a programmable latency, and completes it with a single-cycle `pmem_resp` pulse. It owns the backing line store and flags protocol violations by the initiator.

---
 rtl/pmem_line_responder.sv | 175 +++++++++++++++++
 tb/tb_pmem_line_responder.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// -----------------------------------------------------------------------------
// pmem_line_responder
//
// Memory-side responder for the cache arbiter's line-granular pmem_* port.
// One 256-bit line read or write is accepted at a time. The request is held
// for LATENCY busy cycles, then completed with a one-cycle pmem_resp pulse.
// The block owns the backing line store and raises a sticky flag when the
// initiator breaks the request protocol.
//
// Parameters
//   IDX_WIDTH    line-index bits; the store holds 2**IDX_WIDTH lines
//   LATENCY      busy cycles between request capture and response (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   pmem_read    line read request level, held until pmem_resp
//   pmem_write   line write request level, held until pmem_resp
//   pmem_address byte address; index is [IDX_WIDTH+4:5], other bits ignored
//   pmem_wdata   write line data, captured together with the request
//   pmem_resp    one-cycle completion pulse
//   pmem_rdata   registered read line; holds until the next read completes
//   proto_err    sticky protocol-violation flag, cleared only by rst
// -----------------------------------------------------------------------------
module pmem_line_responder #(
  parameter int IDX_WIDTH = 8,
  parameter int LATENCY   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         proto_err
);

  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  // Only the index field of the byte address selects a line; the offset and
  // the upper bits are dropped on purpose, so the store aliases across them.
  logic [IDX_WIDTH-1:0] req_idx;
  logic                 unused_addr_bits;

  assign req_idx          = pmem_address[IDX_WIDTH+4:5];
  assign unused_addr_bits = ^{pmem_address[31:IDX_WIDTH+5], pmem_address[4:0]};

  // ---------------------------------------------------------------------------
  // Line store
  // ---------------------------------------------------------------------------
  logic [255:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic                 op_rd_q, op_rd_d;     // 1 = read, 0 = write
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [255:0]         wdata_q, wdata_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 resp_q, resp_d;
  logic [255:0]         rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic last_busy;   // final BUSY cycle: the edge that ends it completes the op
  logic busy_mismatch;
  logic mem_we;

  assign last_busy = (state_q == S_BUSY) && (cnt_q == 8'd0);

  // During BUSY the initiator must keep presenting exactly the captured request.
  assign busy_mismatch = (pmem_read  != op_rd_q) ||
                         (pmem_write != !op_rd_q) ||
                         (req_idx    != idx_q);

  // Reset on the completing edge aborts the write, so the commit is gated here.
  assign mem_we = last_busy && !op_rd_q && !rst;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    op_rd_d = op_rd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (pmem_read && pmem_write) begin
          err_d = 1'b1;
        end else if (pmem_read || pmem_write) begin
          op_rd_d = pmem_read;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        if (busy_mismatch) begin
          err_d = 1'b1;
        end
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_RESP;
          resp_d  = 1'b1;
          if (op_rd_q) begin
            rdata_d = mem[idx_q];
          end
        end
      end

      // The initiator's hold-through-resp cycle; its request level is ignored.
      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_rd_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= 8'd0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_rd_q <= op_rd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the store has no reset; clearing a RAM array would turn it into
  // flops, and its power-up contents are undefined anyway.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_line_responder
//
// Self-checking bench for pmem_line_responder. The main instance uses the
// default LATENCY of 4; a second instance is built with LATENCY=1. Expected
// data comes from a line-array model indexed by address bits [12:5], and
// expected response timing from the cycle rules (response at cycle L+1,
// one transaction per L+2 cycles).
// -----------------------------------------------------------------------------
module tb_pmem_line_responder;

  localparam int L = 4;

  logic         clk;
  logic         rst;

  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         proto_err;

  logic         r1_read;
  logic         r1_write;
  logic [31:0]  r1_address;
  logic [255:0] r1_wdata;
  logic         r1_resp;
  logic [255:0] r1_rdata;
  logic         r1_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference line store and which lines hold known data.
  logic [255:0] model_mem   [256];
  bit           model_valid [256];

  pmem_line_responder #(.IDX_WIDTH(8), .LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .proto_err    (proto_err)
  );

  pmem_line_responder #(.IDX_WIDTH(8), .LATENCY(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (r1_read),
    .pmem_write   (r1_write),
    .pmem_address (r1_address),
    .pmem_wdata   (r1_wdata),
    .pmem_resp    (r1_resp),
    .pmem_rdata   (r1_rdata),
    .proto_err    (r1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Runs one transaction on the main instance. Called #1 after a posedge in
  // an IDLE cycle (that cycle is cycle 0); returns #1 after the posedge that
  // starts the cycle following the response. resp_cyc = -1 on timeout.
  task automatic run_txn(input bit is_rd, input logic [31:0] addr,
                         input logic [255:0] wd, output int resp_cyc,
                         output logic [255:0] rd, output logic resp_next);
    pmem_read    = is_rd;
    pmem_write   = !is_rd;
    pmem_address = addr;
    pmem_wdata   = wd;
    resp_cyc     = -1;
    rd           = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        resp_cyc = k;
        rd       = pmem_rdata;
        break;
      end
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(posedge clk); #1;
    resp_next = pmem_resp;
    if (resp_cyc >= 0 && !is_rd) begin
      model_mem[addr[12:5]]   = wd;
      model_valid[addr[12:5]] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== '0 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: resp=%b err=%b rdata=%h, required 0/0/0", pmem_resp, proto_err, pmem_rdata);
    end
    n_checks++;
    if (r1_resp !== 1'b0 || r1_rdata !== '0 || r1_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lat1: resp=%b err=%b rdata=%h, required 0/0/0", r1_resp, r1_err, r1_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int rc; logic [255:0] rd; logic rn;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    run_txn(1'b0, 32'h0000_0040, a5, rc, rd, rn);
    n_checks++;
    if (rc !== L + 1) begin
      n_fail++; $display("FAIL basic_write_latency: resp at cycle %0d, required %0d", rc, L + 1);
    end
    n_checks++;
    if (rn !== 1'b0) begin
      n_fail++; $display("FAIL basic_write_pulse: resp next cycle %b, required 0", rn);
    end
    run_txn(1'b1, 32'h0000_0040, '0, rc, rd, rn);
    n_checks++;
    if (rc !== L + 1) begin
      n_fail++; $display("FAIL basic_read_latency: resp at cycle %0d, required %0d", rc, L + 1);
    end
    n_checks++;
    if (rd !== a5) begin
      n_fail++; $display("FAIL basic_read_data: got %h, required %h", rd, a5);
    end
    n_checks++;
    if (pmem_rdata !== a5) begin
      n_fail++; $display("FAIL basic_rdata_hold: got %h, required %h", pmem_rdata, a5);
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_proto_err: got %b, required 0", proto_err);
    end
  endtask

  task automatic test_alias();
    int rc; logic [255:0] rd; logic rn;
    logic [255:0] one;
    one = 256'h1;
    run_txn(1'b0, 32'h0000_2000, one, rc, rd, rn);
    run_txn(1'b1, 32'h0000_0000, '0, rc, rd, rn);
    n_checks++;
    if (rd !== one || rc !== L + 1) begin
      n_fail++; $display("FAIL alias_wrap: got %h at cycle %0d, required %h at %0d", rd, rc, one, L + 1);
    end
    run_txn(1'b1, 32'h0000_001F, '0, rc, rd, rn);
    n_checks++;
    if (rd !== one) begin
      n_fail++; $display("FAIL alias_offset: got %h, required %h", rd, one);
    end
  endtask

  task automatic test_back_to_back();
    int rc; logic [255:0] rd; logic rn;
    logic [255:0] d3, d7;
    int first, second;
    d3 = rand_line();
    d7 = rand_line();
    run_txn(1'b0, 32'd3 << 5, d3, rc, rd, rn);
    run_txn(1'b0, 32'd7 << 5, d7, rc, rd, rn);
    first  = -1;
    second = -1;
    pmem_read    = 1'b1;
    pmem_address = 32'd3 << 5;
    for (int k = 1; k <= 40 && second < 0; k++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        if (first < 0) begin
          first = k;
          n_checks++;
          if (pmem_rdata !== d3) begin
            n_fail++; $display("FAIL b2b_data_first: got %h, required %h", pmem_rdata, d3);
          end
          pmem_address = 32'd7 << 5;
        end else begin
          second = k;
          n_checks++;
          if (pmem_rdata !== d7) begin
            n_fail++; $display("FAIL b2b_data_second: got %h, required %h", pmem_rdata, d7);
          end
          pmem_read = 1'b0;
        end
      end
    end
    pmem_read = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (first !== L + 1 || second !== 2 * L + 3) begin
      n_fail++; $display("FAIL b2b_timing: resp at %0d and %0d, required %0d and %0d", first, second, L + 1, 2 * L + 3);
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_proto_err: got %b, required 0", proto_err);
    end
  endtask

  task automatic test_random();
    int rc; logic [255:0] rd; logic rn;
    for (int t = 0; t < 30; t++) begin
      bit           is_rd;
      logic [7:0]   idx;
      logic [31:0]  addr;
      logic [255:0] wd;
      is_rd = $urandom_range(0, 1) == 1;
      idx   = 8'($urandom_range(0, 15));
      addr  = ($urandom & 32'hFFFF_E01F) | (32'(idx) << 5);
      wd    = rand_line();
      run_txn(is_rd, addr, wd, rc, rd, rn);
      n_checks++;
      if (rc !== L + 1 || rn !== 1'b0) begin
        n_fail++; $display("FAIL rand_latency[%0d]: resp at %0d (next %b), required %0d", t, rc, rn, L + 1);
      end
      if (is_rd && model_valid[idx]) begin
        n_checks++;
        if (rd !== model_mem[idx]) begin
          n_fail++; $display("FAIL rand_data[%0d] idx %0d: got %h, required %h", t, idx, rd, model_mem[idx]);
        end
      end
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL rand_proto_err: got %b, required 0", proto_err);
    end
  endtask

  task automatic test_proto_both();
    int rc; logic [255:0] rd; logic rn;
    pmem_read    = 1'b1;
    pmem_write   = 1'b1;
    pmem_address = 32'h0000_0040;
    @(posedge clk); #1;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    n_checks++;
    if (proto_err !== 1'b1 || pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL proto_both: err=%b resp=%b, required 1/0", proto_err, pmem_resp);
    end
    // A normal read right after must see the usual latency, i.e. still IDLE.
    run_txn(1'b1, 32'h0000_0040, '0, rc, rd, rn);
    n_checks++;
    if (rc !== L + 1 || rd !== model_mem[2]) begin
      n_fail++; $display("FAIL proto_both_idle: resp at %0d data %h, required %0d data %h", rc, rd, L + 1, model_mem[2]);
    end
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++; $display("FAIL proto_sticky: got %b, required 1", proto_err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL proto_clear: got %b, required 0", proto_err);
    end
  endtask

  task automatic test_addr_change();
    int rc;
    logic [255:0] rd;
    rc           = -1;
    rd           = '0;
    pmem_read    = 1'b1;
    pmem_address = 32'd3 << 5;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 2) pmem_address = 32'd7 << 5;
      if (pmem_resp) begin
        rc = k;
        rd = pmem_rdata;
        break;
      end
    end
    pmem_read = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rc !== L + 1 || rd !== model_mem[3]) begin
      n_fail++; $display("FAIL addr_change_data: resp at %0d data %h, required %0d data %h", rc, rd, L + 1, model_mem[3]);
    end
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++; $display("FAIL addr_change_err: got %b, required 1", proto_err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int rc; logic [255:0] rd; logic rn;
    int rcs [2];
    rcs[0] = 2;
    rcs[1] = L;   // reset on the BUSY->RESP edge itself
    foreach (rcs[j]) begin
      logic [255:0] prior;
      bit saw_resp;
      prior = rand_line();
      run_txn(1'b0, 32'd9 << 5, prior, rc, rd, rn);
      saw_resp     = 1'b0;
      pmem_write   = 1'b1;
      pmem_address = 32'd9 << 5;
      pmem_wdata   = '1;
      for (int k = 1; k <= rcs[j]; k++) begin
        @(posedge clk); #1;
        if (pmem_resp) saw_resp = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst        = 1'b0;
      pmem_write = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (pmem_resp) saw_resp = 1'b1;
        @(posedge clk); #1;
      end
      n_checks++;
      if (saw_resp !== 1'b0 || proto_err !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_write[%0d]: resp seen %b err %b, required 0/0", rcs[j], saw_resp, proto_err);
      end
      run_txn(1'b1, 32'd9 << 5, '0, rc, rd, rn);
      n_checks++;
      if (rd !== prior) begin
        n_fail++; $display("FAIL rst_mid_write_data[%0d]: got %h, required %h", rcs[j], rd, prior);
      end
    end
  endtask

  task automatic test_latency1();
    int rc;
    int resp_cycles [$];
    logic [255:0] d;
    logic [255:0] rd;
    d = rand_line();
    // Write, then read back, each timed from its request cycle.
    for (int pass = 0; pass < 2; pass++) begin
      r1_write   = (pass == 0);
      r1_read    = (pass == 1);
      r1_address = 32'd5 << 5;
      r1_wdata   = d;
      rc = -1;
      rd = '0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (r1_resp) begin
          rc = k;
          rd = r1_rdata;
          break;
        end
      end
      r1_write = 1'b0;
      r1_read  = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rc !== 2) begin
        n_fail++; $display("FAIL lat1_latency[%0d]: resp at %0d, required 2", pass, rc);
      end
    end
    n_checks++;
    if (rd !== d) begin
      n_fail++; $display("FAIL lat1_data: got %h, required %h", rd, d);
    end
    // Continuous request stream: responses at 2, 5, 8, 11.
    r1_read = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (r1_resp) resp_cycles.push_back(k);
    end
    r1_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (resp_cycles.size() != 4) begin
      n_fail++; $display("FAIL lat1_stream_count: got %0d responses, required 4", resp_cycles.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (resp_cycles[i] != 2 + 3 * i) begin
          n_fail++; $display("FAIL lat1_stream_cycle[%0d]: resp at %0d, required %0d", i, resp_cycles[i], 2 + 3 * i);
        end
      end
    end
    n_checks++;
    if (r1_err !== 1'b0) begin
      n_fail++; $display("FAIL lat1_proto_err: got %b, required 0", r1_err);
    end
  endtask

  initial begin
    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    r1_read      = 1'b0;
    r1_write     = 1'b0;
    r1_address   = '0;
    r1_wdata     = '0;
    foreach (model_valid[i]) model_valid[i] = 1'b0;

    test_reset();
    test_basic();
    test_alias();
    test_back_to_back();
    test_random();
    test_proto_both();
    test_addr_change();
    test_reset_mid_write();
    test_latency1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
